// File: rtl/mbist_ctrl.sv
// March C- memory BIST controller.
// It drives a single-port memory through ten operations per word. It compares
// each read against the expected background and keeps the details of the
// first miscompare. Every operation, pipeline and status output is a flop.
module mbist_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ADDR_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_elem
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ADDR_MAX);
    // The drain state spans two cycles. The last read's compare registers on
    // the same edge that raises done, so fail is final in the first done cycle.
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One March operation: element index, address, and phase within the element.
    typedef struct packed {
        logic [2:0]            elem;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  ph;
    } op_t;

    // One stage of the read-compare pipe.
    typedef struct packed {
        logic                  vld;
        logic                  exp;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
    } cmp_t;

    localparam op_t OP_FIRST = '0;

    // Elements 3 and 4 walk the addresses downward. All other elements walk up.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // Elements 0 and 5 have one op per address. Elements 1 to 4 have two (read, then write).
    function automatic logic elem_two_ops(input logic [2:0] e);
        return (e != 3'd0) && (e != 3'd5);
    endfunction

    function automatic logic op_is_last(input op_t o);
        return (o.elem == 3'd5) && (o.addr == ADDR_LAST);
    endfunction

    function automatic logic op_is_write(input op_t o);
        logic w;
        case (o.elem)
            3'd0:    w = 1'b1;
            3'd5:    w = 1'b0;
            default: w = o.ph;
        endcase
        return w;
    endfunction

    // Background bit of an op. Writes in E1/E3 store ones. Reads in E2/E4 expect ones.
    function automatic logic op_bit(input op_t o);
        return op_is_write(o) ? o.elem[0] : ~o.elem[0];
    endfunction

    // Successor op in March C- order. This includes element changes and address wrap.
    function automatic op_t op_adv(input op_t o);
        op_t n;
        n = o;
        if (elem_two_ops(o.elem) && !o.ph) begin
            n.ph = 1'b1;
        end else begin
            n.ph = 1'b0;
            if (elem_down(o.elem)) begin
                if (o.addr == '0) begin
                    n.elem = o.elem + 3'd1;
                    n.addr = (n.elem == 3'd4) ? ADDR_LAST : '0;
                end else begin
                    n.addr = o.addr - ADDR_WIDTH'(1);
                end
            end else begin
                if (o.addr == ADDR_LAST) begin
                    n.elem = o.elem + 3'd1;
                    n.addr = (n.elem == 3'd3) ? ADDR_LAST : '0;
                end else begin
                    n.addr = o.addr + ADDR_WIDTH'(1);
                end
            end
        end
        return n;
    endfunction

    // wdata to present while op o is issued. It carries the next op's write data, or 0.
    function automatic logic [DATA_WIDTH-1:0] lookahead_wdata(input op_t o);
        op_t n;
        n = op_adv(o);
        if (op_is_last(o) || !op_is_write(n)) begin
            return '0;
        end
        return {DATA_WIDTH{op_bit(n)}};
    endfunction

    state_t                state_q,      state_d;
    op_t                   cur_q,        cur_d;
    logic                  write_read_q, write_read_d;
    logic [ADDR_WIDTH-1:0] address_q,    address_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic [1:0]            drain_q,      drain_d;
    cmp_t                  p1_q,         p1_d;
    cmp_t                  p2_q,         p2_d;
    logic                  fail_q,       fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q,  fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q,  fail_data_d;
    logic [2:0]            fail_elem_q,  fail_elem_d;

    op_t  nxt;
    logic launch;
    logic miscmp;

    // Next-state logic: op sequencing, look-ahead write data, compare pipe, and fail capture.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves a value held and no latch is inferred.
        state_d      = state_q;
        cur_d        = cur_q;
        write_read_d = 1'b0;
        address_d    = '0;
        wdata_d      = '0;
        busy_d       = busy_q;
        done_d       = done_q;
        drain_d      = drain_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        fail_elem_d  = fail_elem_q;

        nxt    = op_adv(cur_q);
        launch = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        // The op presented this cycle enters the pipe, so its rdata meets it two cycles later.
        p1_d.vld  = (state_q == ST_RUN) && !write_read_q;
        p1_d.exp  = op_bit(cur_q);
        p1_d.addr = cur_q.addr;
        p1_d.elem = cur_q.elem;
        p2_d      = p1_q;
        miscmp    = p2_q.vld && (rdata != {DATA_WIDTH{p2_q.exp}});

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d      = ST_RUN;
                    cur_d        = OP_FIRST;
                    write_read_d = op_is_write(OP_FIRST);
                    address_d    = OP_FIRST.addr;
                    wdata_d      = lookahead_wdata(OP_FIRST);
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (op_is_last(cur_q)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    cur_d        = nxt;
                    write_read_d = op_is_write(nxt);
                    address_d    = nxt.addr;
                    wdata_d      = lookahead_wdata(nxt);
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_data_d = '0;
            fail_elem_d = '0;
        end else if (miscmp && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = p2_q.addr;
            fail_data_d = rdata;
            fail_elem_d = p2_q.elem;
        end
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            write_read_q <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drain_q      <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            fail_elem_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            cur_q        <= cur_d;
            write_read_q <= write_read_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drain_q      <= drain_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
            fail_elem_q  <= fail_elem_d;
        end
    end

    assign write_read = write_read_q;
    assign address    = address_q;
    assign wdata      = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
    assign fail_elem  = fail_elem_q;

endmodule

// File: tb/tb_mbist_ctrl.sv
// Testbench for mbist_ctrl. A behavioural 16x8 memory model supports one
// injectable stuck-at fault. The stimulus pushes the expected per-cycle op
// trace and the final result of each run into queues. A monitor pops and
// compares these entries while busy is high and when the run ends.
module tb_mbist_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;
    localparam int OPS = 10 * N;
    localparam int BUSY_CYCLES = OPS + 2;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cyc_t;

    typedef struct packed {
        logic          fail;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    elem;
    } res_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          write_read;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [2:0]    fail_elem;

    int checks   = 0;
    int failures = 0;

    cyc_t exp_cyc_q[$];
    res_t exp_res_q[$];

    // Fault injection: kind 0 = none, 1 = stuck-at-1, 2 = stuck-at-0.
    int            flt_kind = 0;
    logic [AW-1:0] flt_addr = '0;
    int            flt_bit  = 0;

    mbist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_MAX(N - 1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .write_read (write_read),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .fail_elem  (fail_elem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model. wdata is sampled one cycle before commit. A write is
    // visible to the next cycle's read, and read data returns two cycles
    // after the read address.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] wd_hold;
    logic [AW-1:0] rd_a1;

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (a == flt_addr && flt_kind == 1) r[flt_bit] = 1'b1;
        if (a == flt_addr && flt_kind == 2) r[flt_bit] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (write_read) mem[address] <= wd_hold;
        wd_hold <= wdata;
        rd_a1   <= address;
        rdata   <= faulty(rd_a1, mem[rd_a1]);
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    // Expected trace for one full run: 160 ops and then two drain cycles with idle outputs.
    task automatic push_run(input res_t r);
        int   wval [6];
        cyc_t ops[$];
        cyc_t c;
        wval = '{0, 1, 0, 1, 0, 0};
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                int nops;
                a    = (e == 3 || e == 4) ? (N - 1 - k) : k;
                nops = (e == 0 || e == 5) ? 1 : 2;
                for (int j = 0; j < nops; j++) begin
                    c.wr    = (e == 0) ? 1'b1 : ((e == 5) ? 1'b0 : (j == 1));
                    c.addr  = AW'(a);
                    c.wdata = {DW{wval[e][0]}};
                    ops.push_back(c);
                end
            end
        end
        for (int i = 0; i < BUSY_CYCLES; i++) begin
            c = '0;
            if (i < OPS) begin
                c.wr   = ops[i].wr;
                c.addr = ops[i].addr;
            end
            if (i + 1 < OPS && ops[i + 1].wr) c.wdata = ops[i + 1].wdata;
            exp_cyc_q.push_back(c);
        end
        exp_res_q.push_back(r);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done && !busy) seen = 1'b1;
        end
        if (!seen) fail_now(name);
    endtask

    task automatic check_idle_outputs(input string name, input logic exp_done);
        check({name, "_wr"},    0, 32'(write_read), 32'd0);
        check({name, "_addr"},  0, 32'(address),    32'd0);
        check({name, "_wdata"}, 0, 32'(wdata),      32'd0);
        check({name, "_busy"},  0, 32'(busy),       32'd0);
        check({name, "_done"},  0, 32'(done),       32'(exp_done));
    endtask

    // Monitor: compare each busy cycle against the trace and each run end against its result.
    initial begin : monitor
        logic busy_prev;
        int   busy_cnt;
        cyc_t ec;
        res_t er;
        busy_prev = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_prev = 1'b0;
            end else begin
                if (busy) begin
                    if (!busy_prev) begin
                        busy_cnt = 0;
                        check("start_clears_status", 0,
                              32'({done, fail, fail_addr, fail_data, fail_elem}), 32'd0);
                    end
                    busy_cnt++;
                    if (exp_cyc_q.size() == 0) begin
                        fail_now("op_queue_empty");
                    end else begin
                        ec = exp_cyc_q.pop_front();
                        check("op_trace", busy_cnt, 32'({write_read, address, wdata}), 32'(ec));
                    end
                end else if (busy_prev) begin
                    check("busy_length", 0, 32'(busy_cnt), 32'(BUSY_CYCLES));
                    check("done_after_busy", 0, 32'(done), 32'd1);
                    if (exp_res_q.size() == 0) begin
                        fail_now("result_queue_empty");
                    end else begin
                        er = exp_res_q.pop_front();
                        check("run_result", 0, 32'({fail, fail_addr, fail_data, fail_elem}), 32'(er));
                    end
                end
                busy_prev = busy;
            end
        end
    end

    initial begin : stimulus
        res_t r;
        start = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("reset", 1'b0);
        check("reset_fail", 0, 32'({fail, fail_addr, fail_data, fail_elem}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Run 1: fault-free memory.
        r = '0;
        push_run(r);
        pulse_start();
        wait_done("run1_done");

        // Run 2: bit 3 of address 7 stuck at 1. The E1 r0 at addr 7 reads 8'h08.
        flt_kind = 1; flt_addr = 4'd7; flt_bit = 3;
        r = '{fail: 1'b1, addr: 4'd7, data: 8'h08, elem: 3'd1};
        push_run(r);
        pulse_start();
        wait_done("run2_done");

        // Run 3: bit 0 of address 0 stuck at 0. The first miscompare is the E2 r1, which reads 8'hFE.
        flt_kind = 2; flt_addr = 4'd0; flt_bit = 0;
        r = '{fail: 1'b1, addr: 4'd0, data: 8'hFE, elem: 3'd2};
        push_run(r);
        pulse_start();
        wait_done("run3_done");

        // Run 4: fault-free memory, with reset asserted in cycle 50 while the run is active.
        flt_kind = 0;
        r = '0;
        push_run(r);
        pulse_start();
        repeat (49) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset", 1'b0);
        check("midrun_reset_fail", 0, 32'({fail, fail_addr, fail_data, fail_elem}), 32'd0);
        exp_cyc_q.delete();
        exp_res_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Run 5: fresh run after the reset. The start pulses in cycles 20 and 100 are ignored.
        push_run(r);
        pulse_start();
        repeat (19) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (79) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("run5_done");

        @(posedge clk);
        #1;
        check_idle_outputs("final_idle", 1'b1);
        check("final_fail", 0, 32'(fail), 32'd0);
        check("queues_drained", 0, 32'(exp_cyc_q.size() + exp_res_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
